top_thermo_codec: RTL and testbench

//  Selectable thermometer-code encoder/decoder with a registered output.
//  - sel=0 (encode): converts a W-bit thermometer code on sw to a K-bit binary count.
//  - sel=1 (decode): converts a K-bit binary value on sw to a W-bit thermometer code.
//  Top-level board block: sw are slide switches, led drives the LED bank.

---
 rtl/top_thermo_codec.sv | 90 +++++++++
 tb/tb_top_thermo_codec.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/top_thermo_codec.sv
// Registered thermometer-code encoder (sel=0) / decoder (sel=1) for the switch/LED board block.
// Optional macro THERMO_CHECK_EN adds a registered err output flagging malformed thermometer codes.
module top_thermo_codec #(
    parameter int K = 3,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sw,
    input  logic         sel,
`ifdef THERMO_CHECK_EN
    output logic         err,
`endif
    output logic [W-1:0] led
);

    generate
        if (K < 1 || K > 8) begin : g_bad_k
            $error("top_thermo_codec: K=%0d outside 1..8", K);
        end
        if (W != (2 ** K) - 1) begin : g_bad_w
            $error("top_thermo_codec: W=%0d must equal 2**K-1 (K=%0d)", W, K);
        end
    endgenerate

    logic [K-1:0] enc_count;
    logic [K-1:0] dec_n;
    logic [W-1:0] dec_therm;
    logic [W-1:0] led_next;
    logic [W-1:0] led_reg;

    // Priority encode: the last set bit seen while scanning upward wins, so bubbles are ignored.
    always_comb begin
        enc_count = '0;
        for (int i = 0; i < W; i++) begin
            if (sw[i]) begin
                enc_count = K'(i + 1);
            end
        end
    end

    assign dec_n = sw[K-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_dec
            localparam logic [K-1:0] IDX = K'(gi);
            assign dec_therm[gi] = (dec_n > IDX);
        end
    endgenerate

    assign led_next = sel ? dec_therm : W'(enc_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg <= '0;
        end else begin
            led_reg <= led_next;
        end
    end

    assign led = led_reg;

`ifdef THERMO_CHECK_EN
    // A valid code never has a 1 directly above a 0; the top bit slot is a constant 0 so W=1 works.
    logic [W-1:0] bubble;
    logic         err_next;
    logic         err_reg;

    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_bubble
            assign bubble[gi] = sw[gi+1] & ~sw[gi];
        end
    endgenerate
    assign bubble[W-1] = 1'b0;

    assign err_next = ~sel & (|bubble);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_top_thermo_codec.sv
// Scoreboard bench for top_thermo_codec: expectations are queued when inputs are driven
// and popped after the following rising edge.
module tb_top_thermo_codec;

    localparam int K = 3;
    localparam int W = 7;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw;
    logic         sel;
    logic [W-1:0] led;
`ifdef THERMO_CHECK_EN
    logic         err;
`endif

    top_thermo_codec #(.K(K), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .sel (sel),
`ifdef THERMO_CHECK_EN
        .err (err),
`endif
        .led (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] led;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_led(input logic [W-1:0] s, input logic sl);
        logic [W-1:0] r;
        int           k;
        r = '0;
        if (sl) begin
            for (int i = 0; i < W; i++) begin
                r[i] = (i < int'(s[K-1:0]));
            end
        end else begin
            k = W;
            while (k > 0 && !s[k-1]) k--;
            r = W'(k);
        end
        return r;
    endfunction

    function automatic logic model_err(input logic [W-1:0] s, input logic sl);
        logic [W-1:0] plus1;
        plus1 = s + W'(1);
        return !sl && ((s & plus1) != '0);
    endfunction

    // One transaction: drive on the falling edge, compare #1 after the next rising edge.
    task automatic step(input logic [W-1:0] s, input logic sl, input logic r, input string tag);
        exp_t e;
        exp_t got_e;
        @(negedge clk);
        sw  = s;
        sel = sl;
        rst = r;
        e.led = r ? '0 : model_led(s, sl);
        e.err = r ? 1'b0 : model_err(s, sl);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, '1, '0);
        end else begin
            got_e = exp_q.pop_front();
            $display("%s rst=%b sel=%b sw=%b led=%b", tag, r, sl, s, led);
            check(tag, led, got_e.led);
`ifdef THERMO_CHECK_EN
            check({tag, "_err"}, W'(err), W'(got_e.err));
`endif
        end
    endtask

    initial begin
        logic [W-1:0] fb;
        logic         sl;
        rst = 1'b1;
        sw  = '0;
        sel = 1'b0;

        // Reset holds led low regardless of inputs
        step(7'b1111111, 1'b0, 1'b1, "rst0");
        step(7'b1111111, 1'b0, 1'b1, "rst1");
        step(7'b1111111, 1'b0, 1'b0, "post_rst");

        // Encode
        step(7'b0000111, 1'b0, 1'b0, "enc_3");
        step(7'b1111111, 1'b0, 1'b0, "enc_full");
        step(7'b0000000, 1'b0, 1'b0, "enc_zero");
        step(7'b0001011, 1'b0, 1'b0, "enc_bubble");
        step(7'b1000000, 1'b0, 1'b0, "enc_top_only");
        step(7'b0000001, 1'b0, 1'b0, "enc_1");

        // Decode
        step(7'b1111101, 1'b1, 1'b0, "dec_upper_ign");
        step(7'b0000000, 1'b1, 1'b0, "dec_zero");
        step(7'b0000111, 1'b1, 1'b0, "dec_full");
        step(7'b0000001, 1'b1, 1'b0, "dec_1");

        // Reset in the middle of traffic
        step(7'b0000111, 1'b1, 1'b1, "rst_mid");

        // Alternating mode with random data
        for (int i = 0; i < 32; i++) begin
            sl = i[0];
            step(W'($urandom), sl, 1'b0, $sformatf("rand%0d", i));
        end

        // Round trip: decode n, feed the DUT's led back in as an encode input
        for (int n = 0; n < 8; n++) begin
            step(W'(n), 1'b1, 1'b0, $sformatf("rt_dec%0d", n));
            fb = led;
            step(fb, 1'b0, 1'b0, $sformatf("rt_enc%0d", n));
            check($sformatf("rt_value%0d", n), led, W'(n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
